// File: rtl/small_comb_result_acc_if.sv
// Bundle of the sample input handshake and the result output handshake for
// small_comb_result_acc. Both channels use the same valid/ready rule: a
// transfer happens on a rising clk edge where valid and ready are both 1,
// valid never depends on ready, and the ready/valid outputs of the
// accumulator come straight from its state register.
interface small_comb_result_acc_if #(
  parameter int SUM_W = 12
);
  logic [7:0]       d_in;
  logic             d_vld;
  logic             d_rdy;
  logic [SUM_W-1:0] res_sum;
  logic [7:0]       res_and_cnt;
  logic [7:0]       res_or_cnt;
  logic             res_par;
  logic             res_vld;
  logic             res_rdy;

  // Producer of samples and consumer of results (the surrounding datapath).
  modport master (
    output d_in, d_vld, res_rdy,
    input  d_rdy, res_sum, res_and_cnt, res_or_cnt, res_par, res_vld
  );

  // The accumulator itself.
  modport slave (
    input  d_in, d_vld, res_rdy,
    output d_rdy, res_sum, res_and_cnt, res_or_cnt, res_par, res_vld
  );
endinterface

// File: rtl/small_comb_result_acc.sv
// Windowed accumulator behind the small combinational logic stage. It
// gathers WIN accepted result words, sums their d_sum fields, counts d_and
// and d_or hits, folds the d_xor bits into one parity bit, and then holds a
// registered result on a valid/ready output until the consumer takes it.
//
// d_in layout: [0] d_f, [1] d_inv, [3:2] d_xor, [5:4] d_sum, [6] d_and,
// [7] d_or. d_f and d_inv carry no statistic here.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// with valid && ready. d_rdy and res_vld decode only the state register, so
// no combinational path exists from d_vld or res_rdy to them.
//
// WIN must lie in 2..255 and 2**SUM_W must exceed 3*WIN so the sum and the
// counters cannot wrap inside one window.
module small_comb_result_acc #(
  parameter int WIN   = 8,
  parameter int SUM_W = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr,
  small_comb_result_acc_if.slave bus,
  output logic                   state_dbg
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(WIN - 1);

  state_t           state, state_nxt;

  logic [7:0]       smp_cnt, smp_cnt_nxt;
  logic [SUM_W-1:0] acc_sum, acc_sum_nxt;
  logic [7:0]       acc_and, acc_and_nxt;
  logic [7:0]       acc_or, acc_or_nxt;
  logic             acc_par, acc_par_nxt;

  logic [SUM_W-1:0] res_sum_q, res_sum_nxt;
  logic [7:0]       res_and_q, res_and_nxt;
  logic [7:0]       res_or_q, res_or_nxt;
  logic             res_par_q, res_par_nxt;

  logic             accept;
  logic             last_smp;
  logic [SUM_W-1:0] sum_ext;
  logic [SUM_W-1:0] sum_add;
  logic [7:0]       and_add;
  logic [7:0]       or_add;
  logic             par_add;

  // d_f and d_inv are part of the word but not accumulated.
  logic             unused_fields;
  assign unused_fields = ^bus.d_in[1:0];

  // Field extraction and zero extension of the incoming word.
  assign sum_ext = {{(SUM_W-2){1'b0}}, bus.d_in[5:4]};
  assign sum_add = acc_sum + sum_ext;
  assign and_add = acc_and + {7'd0, bus.d_in[6]};
  assign or_add  = acc_or  + {7'd0, bus.d_in[7]};
  assign par_add = acc_par ^ bus.d_in[3] ^ bus.d_in[2];

  // A sample is consumed only in ACC with d_vld high; clr drops it.
  assign accept   = (state == ACC) && bus.d_vld && !clr;
  assign last_smp = accept && (smp_cnt == LAST_IDX);

  // Next state, next accumulators and next result registers; defaults hold.
  always_comb begin
    state_nxt   = state;
    smp_cnt_nxt = smp_cnt;
    acc_sum_nxt = acc_sum;
    acc_and_nxt = acc_and;
    acc_or_nxt  = acc_or;
    acc_par_nxt = acc_par;
    res_sum_nxt = res_sum_q;
    res_and_nxt = res_and_q;
    res_or_nxt  = res_or_q;
    res_par_nxt = res_par_q;

    if (clr) begin
      // Window restarts; the last result stays readable but is not flagged.
      state_nxt   = ACC;
      smp_cnt_nxt = '0;
      acc_sum_nxt = '0;
      acc_and_nxt = '0;
      acc_or_nxt  = '0;
      acc_par_nxt = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (last_smp) begin
            // Final sample goes straight into the result, not the accumulator.
            res_sum_nxt = sum_add;
            res_and_nxt = and_add;
            res_or_nxt  = or_add;
            res_par_nxt = par_add;
            smp_cnt_nxt = '0;
            acc_sum_nxt = '0;
            acc_and_nxt = '0;
            acc_or_nxt  = '0;
            acc_par_nxt = 1'b0;
            state_nxt   = OUT;
          end else if (accept) begin
            smp_cnt_nxt = smp_cnt + 8'd1;
            acc_sum_nxt = sum_add;
            acc_and_nxt = and_add;
            acc_or_nxt  = or_add;
            acc_par_nxt = par_add;
          end
        end
        OUT: begin
          if (bus.res_rdy) begin
            state_nxt = ACC;
          end
        end
        default: begin
          state_nxt = ACC;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Window accumulators and sample counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      smp_cnt <= '0;
      acc_sum <= '0;
      acc_and <= '0;
      acc_or  <= '0;
      acc_par <= 1'b0;
    end else begin
      smp_cnt <= smp_cnt_nxt;
      acc_sum <= acc_sum_nxt;
      acc_and <= acc_and_nxt;
      acc_or  <= acc_or_nxt;
      acc_par <= acc_par_nxt;
    end
  end

  // Result registers, loaded on the last sample of a window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      res_sum_q <= '0;
      res_and_q <= '0;
      res_or_q  <= '0;
      res_par_q <= 1'b0;
    end else begin
      res_sum_q <= res_sum_nxt;
      res_and_q <= res_and_nxt;
      res_or_q  <= res_or_nxt;
      res_par_q <= res_par_nxt;
    end
  end

  // Handshake flags decode the state register only.
  assign bus.d_rdy       = (state == ACC);
  assign bus.res_vld     = (state == OUT);
  assign bus.res_sum     = res_sum_q;
  assign bus.res_and_cnt = res_and_q;
  assign bus.res_or_cnt  = res_or_q;
  assign bus.res_par     = res_par_q;
  assign state_dbg       = state;

endmodule

// File: doc/small_comb_result_acc.md
# small_comb_result_acc

Windowed accumulator that sits directly downstream of the small combinational logic stage. It consumes that stage's 8-bit result word, which carries the fields d_f, d_inv, d_xor, d_sum, d_and and d_or. Over a window of WIN accepted samples it accumulates statistics on those fields. It then presents one registered result through a valid/ready handshake, so the combinational stage can feed a sequential, back-pressured datapath.

## Interface
- WIN, 8: samples per window; legal range 2..255.
- SUM_W, 12: width of res_sum; must satisfy 2^SUM_W > 3*WIN.
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising clk.
- clr  in  1  synchronous active-high window clear.
- d_in  in  8  result word from the comb stage:
  - [0] d_f, [1] d_inv, [3:2] d_xor, [5:4] d_sum, [6] d_and, [7] d_or.
- d_vld  in  1  d_in valid.
- d_rdy  out  1  block can accept a sample this cycle.
- res_sum  out  SUM_W  sum of the d_sum fields over the window (unsigned).
- res_and_cnt  out  8  number of samples with d_and=1.
- res_or_cnt  out  8  number of samples with d_or=1.
- res_par  out  1  XOR of d_xor[1]^d_xor[0] over all window samples.
- res_vld  out  1  result valid.
- res_rdy  in  1  result consumer ready.

## Operation
- Accept event: d_vld && d_rdy on a rising edge.
- FSM states:
  - ACC (reset state): d_rdy=1, res_vld=0.
  - OUT: d_rdy=0, res_vld=1.
- In ACC, each accepted sample updates the accumulators:
  - acc_sum += d_in[5:4], zero-extended to SUM_W.
  - acc_and += d_in[6].
  - acc_or += d_in[7].
  - acc_par ^= d_in[3]^d_in[2].
  - smp_cnt += 1.
- When the accepted sample is the WIN-th (smp_cnt==WIN-1 at accept):
  - Result registers load the final accumulator values, including that sample.
  - FSM goes to OUT.
  - Accumulators and smp_cnt clear to 0 in the same edge.
- In OUT:
  - res_* outputs are held stable.
  - d_vld is ignored; no sample is consumed.
- OUT -> ACC on res_vld && res_rdy.
- No overflow is possible when the SUM_W constraint is met. Counters never wrap inside a window.
- clr:
  - smp_cnt and all accumulators go to 0, FSM goes to ACC, res_vld goes to 0.
  - Result registers keep their values but are no longer flagged valid.
  - clr together with an accept: clr wins and the sample is dropped.
  - clr together with a res handshake: the handshake completes and clr still applies.
- resetn=0 takes priority over everything:
  - FSM=ACC, smp_cnt=0, accumulators=0.
  - res_sum=0, res_and_cnt=0, res_or_cnt=0, res_par=0, res_vld=0, d_rdy=1.
  - This applies from the first rising edge with resetn low, including mid-window and during OUT.

## Timing
- d_rdy and res_vld are decoded directly from the FSM state register. They carry no combinational path from d_vld or res_rdy.
- Latency: WIN-th sample accepted at edge k -> res_vld=1 and res_* valid from edge k until the handshake.
- Minimum window period: WIN+1 cycles, i.e. WIN accept cycles plus one OUT cycle with res_rdy held high.
- Next-window sample: the earliest accept is the edge after the OUT->ACC handshake edge.
- Idle cycles (d_vld=0) inside a window leave all state unchanged. They may occur between any two samples.
- Back-pressure: in OUT with res_rdy=0, the FSM and res_* stay frozen indefinitely.

## Test plan
- Full window:
  - Reset, then 8 consecutive samples of 0xFF.
  - Required: res_vld rises on the edge of the 8th accept.
  - Required: res_sum=24, res_and_cnt=8, res_or_cnt=8, res_par=0.
- Parity and sum:
  - 7 samples of 0x14, then 1 sample of 0x00.
  - Required: res_sum=7, res_and_cnt=0, res_or_cnt=0, res_par=1.
- Gapped input:
  - Samples 0x30, 0x40, 0x80, 0x00, 0x30, 0x40, 0x80, 0x00 with d_vld low for 3 cycles between each.
  - Required: res_sum=6, res_and_cnt=2, res_or_cnt=2, res_par=0.
  - Required: no sample is lost or double-counted.
- Back-pressure:
  - Complete a window with res_rdy=0 for 5 cycles.
  - Required: res_vld=1, d_rdy=0 and res_* constant for all 5 cycles; d_vld pulses are ignored.
  - Required: res_rdy=1 gives d_rdy=1 on the next cycle.
- Mid-window reset and clear:
  - Accept 5 samples of 0xFF, pull resetn low for 1 cycle, then send 8 samples of 0x10.
  - Required: all outputs are 0 and d_rdy=1 during reset; the result is res_sum=8, res_and_cnt=0, res_par=0.
  - Repeat using clr asserted together with the 5th accept.
  - Required: that 5th sample is dropped.
